// File: rtl/hdlc_mon_pkg.sv
// Shared definitions for the HDLC receive-path protocol monitor.
package hdlc_mon_pkg;

  localparam logic [7:0] HDLC_FLAG  = 8'h7E;
  localparam int         NUM_CAUSES = 3;

  typedef enum logic [1:0] {
    ERR_FLAG_MISS  = 2'd0,
    ERR_FLAG_SPUR  = 2'd1,
    ERR_ABORT_MISS = 2'd2
  } err_cause_t;

  // Increment that sticks at the all-ones value of a width-bit counter (width <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (value >= max_val) ? max_val : value + 32'd1;
  endfunction

endpackage

// File: rtl/hdlc_rx_mon_ch.sv
// One channel of the HDLC Rx monitor: flag/abort expectation pipes, idle run
// counter and three saturating per-cause error counters.
module hdlc_rx_mon_ch
  import hdlc_mon_pkg::*;
#(
  parameter int CNT_W          = 16,
  parameter int FLAG_LAT       = 2,
  parameter int ABORT_LAT      = 1,
  parameter int IDLE_LEN       = 8,
  parameter int CHECK_SPURIOUS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             rx,
  input  logic             flag_detect,
  input  logic             abort_detect,
  input  logic             valid_frame,
  input  logic             abort_signal,
  output logic             idle,
  output logic             err_evt,
  output logic             err_sticky,
  output logic [CNT_W-1:0] flag_miss_cnt,
  output logic [CNT_W-1:0] flag_spur_cnt,
  output logic [CNT_W-1:0] abort_miss_cnt
);

  // Only the seven most recent samples ever reach the flag compare alongside rx.
  logic [6:0]           sr_reg, sr_next;
  logic                 flag_hit;
  logic                 abort_hit;
  logic [FLAG_LAT-1:0]  flag_pipe_reg, flag_pipe_next;
  logic [ABORT_LAT-1:0] abort_pipe_reg, abort_pipe_next;
  logic [7:0]           run_reg, run_next;
  logic                 idle_reg, evt_reg, sticky_reg;
  logic                 flag_expect, abort_expect;
  logic [NUM_CAUSES-1:0] err_vec;
  logic                 err_any;
  logic [CNT_W-1:0]     cnt_q [NUM_CAUSES];

  assign sr_next   = {sr_reg[5:0], rx};
  assign flag_hit  = ({sr_reg, rx} == HDLC_FLAG);
  assign abort_hit = abort_detect & valid_frame;

  if (FLAG_LAT == 1) begin : g_fpipe_one
    assign flag_pipe_next = flag_hit;
  end else begin : g_fpipe_many
    assign flag_pipe_next = {flag_pipe_reg[FLAG_LAT-2:0], flag_hit};
  end

  if (ABORT_LAT == 1) begin : g_apipe_one
    assign abort_pipe_next = abort_hit;
  end else begin : g_apipe_many
    assign abort_pipe_next = {abort_pipe_reg[ABORT_LAT-2:0], abort_hit};
  end

  assign flag_expect  = flag_pipe_reg[FLAG_LAT-1];
  assign abort_expect = abort_pipe_reg[ABORT_LAT-1];

  assign run_next = !rx ? 8'd0 :
                    (run_reg == 8'(IDLE_LEN)) ? run_reg : run_reg + 8'd1;

  assign err_vec[ERR_FLAG_MISS]  = en & flag_expect & ~flag_detect;
  assign err_vec[ERR_FLAG_SPUR]  = en & flag_detect & ~flag_expect & (CHECK_SPURIOUS != 0);
  assign err_vec[ERR_ABORT_MISS] = en & abort_expect & ~abort_signal;
  assign err_any = |err_vec;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_reg         <= '0;
      flag_pipe_reg  <= '0;
      abort_pipe_reg <= '0;
      run_reg        <= '0;
      idle_reg       <= 1'b0;
      evt_reg        <= 1'b0;
      sticky_reg     <= 1'b0;
    end else begin
      if (en) begin
        sr_reg         <= sr_next;
        flag_pipe_reg  <= flag_pipe_next;
        abort_pipe_reg <= abort_pipe_next;
        run_reg        <= run_next;
        idle_reg       <= (run_next == 8'(IDLE_LEN));
      end
      // err_any is already gated by en, so a frozen monitor never pulses.
      evt_reg    <= err_any;
      sticky_reg <= clr ? 1'b0 : (sticky_reg | err_any);
    end
  end

  for (genvar gi = 0; gi < NUM_CAUSES; gi++) begin : g_cnt
    logic [CNT_W-1:0] cnt_reg;
    always_ff @(posedge clk) begin
      if (rst || clr) begin
        cnt_reg <= '0;
      end else if (err_vec[gi]) begin
        cnt_reg <= CNT_W'(sat_inc(32'(cnt_reg), CNT_W));
      end
    end
    assign cnt_q[gi] = cnt_reg;
  end

  assign idle           = idle_reg;
  assign err_evt        = evt_reg;
  assign err_sticky     = sticky_reg;
  assign flag_miss_cnt  = cnt_q[ERR_FLAG_MISS];
  assign flag_spur_cnt  = cnt_q[ERR_FLAG_SPUR];
  assign abort_miss_cnt = cnt_q[ERR_ABORT_MISS];

endmodule

// File: rtl/hdlc_rx_protocol_monitor.sv
// Multi-channel HDLC Rx protocol monitor: one independent checker per channel,
// counters packed with channel c at bits [c*CNT_W +: CNT_W].
module hdlc_rx_protocol_monitor
  import hdlc_mon_pkg::*;
#(
  parameter int NUM_CH         = 1,
  parameter int CNT_W          = 16,
  parameter int FLAG_LAT       = 2,
  parameter int ABORT_LAT      = 1,
  parameter int IDLE_LEN       = 8,
  parameter int CHECK_SPURIOUS = 1
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic                    En,
  input  logic                    Clr,
  input  logic [NUM_CH-1:0]       Rx,
  input  logic [NUM_CH-1:0]       Rx_FlagDetect,
  input  logic [NUM_CH-1:0]       Rx_AbortDetect,
  input  logic [NUM_CH-1:0]       Rx_ValidFrame,
  input  logic [NUM_CH-1:0]       Rx_AbortSignal,
  output logic [NUM_CH-1:0]       Idle,
  output logic [NUM_CH-1:0]       ErrEvt,
  output logic [NUM_CH-1:0]       ErrSticky,
  output logic [NUM_CH*CNT_W-1:0] FlagMissCnt,
  output logic [NUM_CH*CNT_W-1:0] FlagSpurCnt,
  output logic [NUM_CH*CNT_W-1:0] AbortMissCnt
);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    hdlc_rx_mon_ch #(
      .CNT_W          (CNT_W),
      .FLAG_LAT       (FLAG_LAT),
      .ABORT_LAT      (ABORT_LAT),
      .IDLE_LEN       (IDLE_LEN),
      .CHECK_SPURIOUS (CHECK_SPURIOUS)
    ) u_ch (
      .clk            (Clk),
      .rst            (Rst),
      .en             (En),
      .clr            (Clr),
      .rx             (Rx[gi]),
      .flag_detect    (Rx_FlagDetect[gi]),
      .abort_detect   (Rx_AbortDetect[gi]),
      .valid_frame    (Rx_ValidFrame[gi]),
      .abort_signal   (Rx_AbortSignal[gi]),
      .idle           (Idle[gi]),
      .err_evt        (ErrEvt[gi]),
      .err_sticky     (ErrSticky[gi]),
      .flag_miss_cnt  (FlagMissCnt[gi*CNT_W +: CNT_W]),
      .flag_spur_cnt  (FlagSpurCnt[gi*CNT_W +: CNT_W]),
      .abort_miss_cnt (AbortMissCnt[gi*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_hdlc_rx_protocol_monitor.sv
// Directed bench for hdlc_rx_protocol_monitor with a sample-history reference model.
module tb_hdlc_rx_protocol_monitor;

  localparam int NCH   = 4;
  localparam int CW    = 4;
  localparam int FLAT  = 2;
  localparam int ALAT  = 1;
  localparam int ILEN  = 8;
  localparam int CMAX  = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst, en, clr;
  logic [NCH-1:0] rx, fd, ad, vf, abort_sig;
  logic [NCH-1:0] idle, evt, sticky;
  logic [NCH*CW-1:0] miss_cnt, spur_cnt, amiss_cnt;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  hdlc_rx_protocol_monitor #(
    .NUM_CH(NCH), .CNT_W(CW), .FLAG_LAT(FLAT), .ABORT_LAT(ALAT),
    .IDLE_LEN(ILEN), .CHECK_SPURIOUS(1)
  ) dut (
    .Clk(clk), .Rst(rst), .En(en), .Clr(clr),
    .Rx(rx), .Rx_FlagDetect(fd), .Rx_AbortDetect(ad),
    .Rx_ValidFrame(vf), .Rx_AbortSignal(abort_sig),
    .Idle(idle), .ErrEvt(evt), .ErrSticky(sticky),
    .FlagMissCnt(miss_cnt), .FlagSpurCnt(spur_cnt), .AbortMissCnt(amiss_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Keeps the raw sample history per channel and a list of due check times
  // (counted in enabled cycles) for flag and abort expectations.
  bit hist  [NCH][$];
  int due_f [NCH][$];
  int due_a [NCH][$];
  int m_miss [NCH];
  int m_spur [NCH];
  int m_amiss[NCH];
  bit m_idle [NCH];
  bit m_evt  [NCH];
  bit m_sticky[NCH];
  int ecyc = 0;

  function automatic int sat1(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  always @(posedge clk) begin
    logic [7:0] last8;
    bit ef, ea, mi, sp, am, ones;
    int n;
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        hist[c].delete();
        for (int k = 0; k < 8; k++) hist[c].push_back(1'b0);
        due_f[c].delete();
        due_a[c].delete();
        m_miss[c] = 0; m_spur[c] = 0; m_amiss[c] = 0;
        m_idle[c] = 0; m_evt[c] = 0; m_sticky[c] = 0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (en) begin
          hist[c].push_back(rx[c]);
          if (hist[c].size() > 64) void'(hist[c].pop_front());
          n = hist[c].size();
          last8 = 8'h00;
          for (int k = 0; k < 8; k++) last8 = {last8[6:0], hist[c][n-8+k]};
          if (last8 == 8'b0111_1110) due_f[c].push_back(ecyc + FLAT);
          if (ad[c] && vf[c]) due_a[c].push_back(ecyc + ALAT);
          ef = (due_f[c].size() > 0) && (due_f[c][0] == ecyc);
          if (ef) void'(due_f[c].pop_front());
          ea = (due_a[c].size() > 0) && (due_a[c][0] == ecyc);
          if (ea) void'(due_a[c].pop_front());
          mi = ef && !fd[c];
          sp = fd[c] && !ef;
          am = ea && !abort_sig[c];
          m_evt[c] = mi | sp | am;
          if (clr) begin
            m_miss[c] = 0; m_spur[c] = 0; m_amiss[c] = 0; m_sticky[c] = 0;
          end else begin
            if (mi) m_miss[c]  = sat1(m_miss[c]);
            if (sp) m_spur[c]  = sat1(m_spur[c]);
            if (am) m_amiss[c] = sat1(m_amiss[c]);
            m_sticky[c] = m_sticky[c] | m_evt[c];
          end
          ones = 1'b1;
          for (int k = 0; k < ILEN; k++) if (!hist[c][n-1-k]) ones = 1'b0;
          m_idle[c] = ones;
        end else begin
          m_evt[c] = 1'b0;
          if (clr) begin
            m_miss[c] = 0; m_spur[c] = 0; m_amiss[c] = 0; m_sticky[c] = 0;
          end
        end
      end
      if (en) ecyc++;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      for (int c = 0; c < NCH; c++) begin
        check($sformatf("model_idle_ch%0d", c),   64'(idle[c]),   64'(m_idle[c]));
        check($sformatf("model_evt_ch%0d", c),    64'(evt[c]),    64'(m_evt[c]));
        check($sformatf("model_sticky_ch%0d", c), 64'(sticky[c]), 64'(m_sticky[c]));
        check($sformatf("model_miss_ch%0d", c),  64'(miss_cnt[c*CW +: CW]),  64'(m_miss[c]));
        check($sformatf("model_spur_ch%0d", c),  64'(spur_cnt[c*CW +: CW]),  64'(m_spur[c]));
        check($sformatf("model_amiss_ch%0d", c), 64'(amiss_cnt[c*CW +: CW]), 64'(m_amiss[c]));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic quiet();
    rx = '1; fd = '0; ad = '0; vf = '0; abort_sig = '0; clr = 1'b0; en = 1'b1;
  endtask

  // Sends 0,1,1,1,1,1,1,0 on the channels in chmask and answers with fd two cycles after the closing 0.
  task automatic send_flag(input logic [NCH-1:0] chmask, input logic [NCH-1:0] fdmask);
    logic [7:0] pat;
    pat = 8'h7E;
    for (int i = 7; i >= 0; i--) begin
      rx = pat[i] ? '1 : ~chmask;
      cyc();
    end
    rx = '1;
    cyc();
    check("evt_before_check", 64'(evt), 64'(0));
    fd = fdmask;
    cyc();
    fd = '0;
    check("evt_after_check", 64'(evt), 64'(chmask & ~fdmask));
    cyc();
    check("evt_single_pulse", 64'(evt), 64'(0));
    $display("flag tx ch=%b fd=%b miss=%h", chmask, fdmask, miss_cnt);
  endtask

  initial begin
    quiet();
    rst = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;
    chk_on = 1'b1;
    check("reset_idle",   64'(idle),      64'(0));
    check("reset_evt",    64'(evt),       64'(0));
    check("reset_sticky", 64'(sticky),    64'(0));
    check("reset_miss",   64'(miss_cnt),  64'(0));
    check("reset_spur",   64'(spur_cnt),  64'(0));
    check("reset_amiss",  64'(amiss_cnt), 64'(0));
    repeat (10) cyc();

    // 1: well-behaved flag
    send_flag(4'b0001, 4'b0001);
    check("t1_miss",   64'(miss_cnt), 64'(0));
    check("t1_spur",   64'(spur_cnt), 64'(0));
    check("t1_sticky", 64'(sticky),   64'(0));

    // 2: flag detect withheld
    send_flag(4'b0001, 4'b0000);
    check("t2_miss",   64'(miss_cnt), 64'h0001);
    check("t2_sticky", 64'(sticky),   64'(4'b0001));

    // 3: abort with and without valid frame, then a correctly signalled one
    ad[0] = 1'b1; vf[0] = 1'b1; cyc();
    ad[0] = 1'b0; vf[0] = 1'b0; cyc();
    check("t3_abort_evt", 64'(evt), 64'(4'b0001));
    cyc();
    check("t3_amiss", 64'(amiss_cnt), 64'h0001);
    $display("abort tx valid=1 amiss=%h", amiss_cnt);
    ad[0] = 1'b1; cyc();
    ad[0] = 1'b0; cyc(); cyc();
    check("t3_amiss_novalid", 64'(amiss_cnt), 64'h0001);
    $display("abort tx valid=0 amiss=%h", amiss_cnt);
    ad[0] = 1'b1; vf[0] = 1'b1; cyc();
    ad[0] = 1'b0; vf[0] = 1'b0; abort_sig[0] = 1'b1; cyc();
    abort_sig[0] = 1'b0; cyc();
    check("t3_amiss_signalled", 64'(amiss_cnt), 64'h0001);
    $display("abort tx signalled amiss=%h", amiss_cnt);

    // 4: idle line
    check("t4_idle_long", 64'(idle), 64'hF);
    rx[0] = 1'b0; cyc();
    check("t4_idle_fall", 64'(idle), 64'hE);
    rx[0] = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      if (i == 7) check("t4_idle_7ones", 64'(idle[0]), 64'(0));
    end
    check("t4_idle_8ones", 64'(idle[0]), 64'(1));
    rx[0] = 1'b0; cyc();
    check("t4_idle_zero", 64'(idle[0]), 64'(0));
    rx[0] = 1'b1; repeat (7) cyc();
    check("t4_idle_only7", 64'(idle[0]), 64'(0));
    rx[0] = 1'b0; cyc();
    rx[0] = 1'b1; repeat (9) cyc();
    $display("idle run idle=%b", idle);

    // 5: spurious saturation and Clr racing an error
    fd[0] = 1'b1; repeat (20) cyc();
    fd[0] = 1'b0; cyc();
    check("t5_spur_sat", 64'(spur_cnt), 64'h000F);
    $display("spur x20 spur=%h", spur_cnt);
    fd[0] = 1'b1; clr = 1'b1; cyc();
    fd[0] = 1'b0; clr = 1'b0;
    check("t5_clr_spur",   64'(spur_cnt), 64'(0));
    check("t5_clr_miss",   64'(miss_cnt), 64'(0));
    check("t5_clr_evt",    64'(evt),      64'(4'b0001));
    check("t5_clr_sticky", 64'(sticky),   64'(0));
    cyc();

    // 6: reset discards an in-flight flag expectation
    begin
      logic [7:0] pat;
      pat = 8'h7E;
      for (int i = 7; i >= 0; i--) begin
        rx[0] = pat[i]; cyc();
      end
      rx[0] = 1'b1; rst = 1'b1; cyc();
      rst = 1'b0;
      check("t6_rst_idle",   64'(idle),      64'(0));
      check("t6_rst_evt",    64'(evt),       64'(0));
      check("t6_rst_sticky", 64'(sticky),    64'(0));
      check("t6_rst_amiss",  64'(amiss_cnt), 64'(0));
      repeat (4) cyc();
      check("t6_rst_nomiss", 64'(miss_cnt), 64'(0));
      $display("reset after flag miss=%h", miss_cnt);
    end
    repeat (10) cyc();
    send_flag(4'b1010, 4'b0000);
    check("t6_multi_miss", 64'(miss_cnt), 64'h1010);

    // back-to-back flags sharing a zero on ch2, both unanswered
    begin
      logic [13:0] pat2;
      pat2 = 14'b01111110111111;
      for (int i = 13; i >= 0; i--) begin
        rx[2] = pat2[i]; cyc();
      end
      rx[2] = 1'b0; cyc();
      rx[2] = 1'b1; repeat (4) cyc();
      check("t6_shared_zero", 64'(miss_cnt), 64'h1210);
      $display("shared-zero flags miss=%h", miss_cnt);
    end

    // frozen monitor: pattern and detect pulses with En low are ignored
    en = 1'b0;
    begin
      logic [7:0] pat;
      pat = 8'h7E;
      for (int i = 7; i >= 0; i--) begin
        rx[1] = pat[i]; fd[0] = pat[i]; cyc();
      end
    end
    rx = '1; fd = '0; cyc();
    check("t7_frozen_spur", 64'(spur_cnt), 64'(0));
    en = 1'b1; repeat (5) cyc();
    $display("enable low spur=%h miss=%h", spur_cnt, miss_cnt);

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
